// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM and palette between two players.
// Three-stage pipeline: accept/address, ROM data, palette result with per-requester strobe.
module sprite_rom_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter logic [3:0]  TRANSP_IDX = 4'd0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_blank,
  input  logic [1:0]        i_req,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic [1:0]        o_gnt,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [3:0]        i_rom_data,
  output logic [3:0]        o_pal_index,
  input  logic [11:0]       i_pal_rgb,
  output logic [1:0]        o_rvalid,
  output logic [11:0]       o_rgb,
  output logic              o_transparent,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            r_state;
  logic              r_last_id;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_s1_valid, r_s1_id;
  logic              r_s2_valid, r_s2_id;
  logic [1:0]        r_rvalid;
  logic [11:0]       r_rgb;
  logic              r_transparent;

  logic w_grant_ok, w_gnt_id, w_accept, w_pipe_empty;

  always_comb begin
    w_grant_ok = (r_state == StRun) && i_en && !i_blank;
    w_gnt_id   = 1'b0;
    case (i_req)
      2'b01:   w_gnt_id = 1'b0;
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = ~r_last_id;
      default: w_gnt_id = 1'b0;
    endcase
    o_gnt = 2'b00;
    if (w_grant_ok && (i_req != 2'b00)) begin
      o_gnt = w_gnt_id ? 2'b10 : 2'b01;
    end
    // A grant is only issued to an active requester, so any grant is an accept.
    w_accept     = |(i_req & o_gnt);
    w_pipe_empty = !r_s1_valid && !r_s2_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_last_id     <= 1'b1;
      r_rom_addr    <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_id       <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_id       <= 1'b0;
      r_rvalid      <= 2'b00;
      r_rgb         <= 12'h000;
      r_transparent <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        StIdle:  if (!i_blank) r_state <= StRun;
        StRun:   if (i_blank) r_state <= StDrain;
        StDrain: begin
          if (w_pipe_empty)  r_state <= StIdle;
          else if (!i_blank) r_state <= StRun;
        end
        default: r_state <= StIdle;
      endcase

      if (w_accept) begin
        r_last_id  <= w_gnt_id;
        r_rom_addr <= w_gnt_id ? i_addr1 : i_addr0;
      end
      r_s1_valid <= w_accept;
      r_s1_id    <= w_gnt_id;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;

      if (r_s2_valid) begin
        r_rvalid      <= r_s2_id ? 2'b10 : 2'b01;
        r_rgb         <= i_pal_rgb;
        r_transparent <= (i_rom_data == TRANSP_IDX);
      end else begin
        r_rvalid <= 2'b00;
      end
    end
  end

  assign o_rom_addr    = r_rom_addr;
  assign o_pal_index   = i_rom_data;
  assign o_rvalid      = r_rvalid;
  assign o_rgb         = r_rgb;
  assign o_transparent = r_transparent;
  assign o_busy        = (r_state != StIdle) || r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 1-edge ROM returning addr[3:0]
// and a palette returning {idx, ~idx, idx}.
module tb_sprite_rom_arbiter;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              blank;
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data = 4'h0;
  logic [3:0]        pal_index;
  logic [11:0]       pal_rgb;
  logic [1:0]        rvalid;
  logic [11:0]       rgb;
  logic              transparent;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr[3:0];
  assign pal_rgb = {pal_index, ~pal_index, pal_index};

  sprite_rom_arbiter #(.ADDR_W(ADDR_W), .TRANSP_IDX(4'd0)) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_blank       (blank),
    .i_req         (req),
    .i_addr0       (addr0),
    .i_addr1       (addr1),
    .o_gnt         (gnt),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_pal_index   (pal_index),
    .i_pal_rgb     (pal_rgb),
    .o_rvalid      (rvalid),
    .o_rgb         (rgb),
    .o_transparent (transparent),
    .o_busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then one enabled edge with blank=0 to reach RUN.
  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b1; blank = 1'b0; req = 2'b00; addr0 = '0; addr1 = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; blank = 1'b1; req = 2'b11; addr0 = '0; addr1 = '0;
    #3;
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
    n_tests++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_tests++; if (transparent !== 1'b0) begin n_fail++; $display("FAIL reset_transp: got %b want 0", transparent); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    tick();
    rst_n = 1'b1; req = 2'b00; blank = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 2'b01; addr0 = 17'h00005;
    #1;
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", gnt); end
    tick();
    req = 2'b00;
    n_tests++; if (rom_addr !== 17'h00005) begin n_fail++; $display("FAIL single_rom_addr: got %h want 00005", rom_addr); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b want 00", rvalid); end
    tick();
    n_tests++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL single_rvalid: got %b want 01", rvalid); end
    n_tests++; if (rgb !== 12'h5A5) begin n_fail++; $display("FAIL single_rgb: got %h want 5A5", rgb); end
    n_tests++; if (transparent !== 1'b0) begin n_fail++; $display("FAIL single_transp: got %b want 0", transparent); end
    tick();
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL single_clear: got %b want 00", rvalid); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [11:0] exp_rgb [4] = '{12'h1E1, 12'h2D2, 12'h1E1, 12'h2D2};
    apply_reset();
    req = 2'b11; addr0 = 17'h00001; addr1 = 17'h00002;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req = 2'b00;
      #1;
      if (k < 4) begin
        n_tests++;
        if (gnt !== exp_gnt[k]) begin
          n_fail++; $display("FAIL contention_gnt[%0d]: got %b want %b", k, gnt, exp_gnt[k]);
        end
      end
      tick();
      if (k >= 2) begin
        n_tests++;
        if (rvalid !== exp_gnt[k-2]) begin
          n_fail++; $display("FAIL contention_rvalid[%0d]: got %b want %b", k-2, rvalid, exp_gnt[k-2]);
        end
        n_tests++;
        if (rgb !== exp_rgb[k-2]) begin
          n_fail++; $display("FAIL contention_rgb[%0d]: got %h want %h", k-2, rgb, exp_rgb[k-2]);
        end
      end
    end
  endtask

  task automatic test_transparency();
    req = 2'b10; addr1 = 17'h00010;
    #1;
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL transp_gnt: got %b want 10", gnt); end
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tests++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL transp_rvalid: got %b want 10", rvalid); end
    n_tests++; if (transparent !== 1'b1) begin n_fail++; $display("FAIL transp_flag: got %b want 1", transparent); end
    n_tests++; if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL transp_rgb: got %h want 0F0", rgb); end
  endtask

  task automatic test_en_toggle();
    req = 2'b01; addr0 = 17'h00003; en = 1'b1;
    tick();
    req = 2'b00; en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++; if (rom_addr !== 17'h00003) begin n_fail++; $display("FAIL en_hold_addr[%0d]: got %h want 00003", k, rom_addr); end
      n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL en_hold_rvalid[%0d]: got %b want 00", k, rvalid); end
      n_tests++; if (rgb !== 12'h0F0) begin n_fail++; $display("FAIL en_hold_rgb[%0d]: got %h want 0F0", k, rgb); end
    end
    en = 1'b1;
    tick();
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL en_early: got %b want 00", rvalid); end
    tick();
    n_tests++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL en_rvalid: got %b want 01", rvalid); end
    n_tests++; if (rgb !== 12'h3C3) begin n_fail++; $display("FAIL en_rgb: got %h want 3C3", rgb); end
  endtask

  task automatic test_blank_drain();
    req = 2'b11; addr0 = 17'h00004; addr1 = 17'h00006;
    tick();
    tick();
    blank = 1'b1;
    #1;
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL drain_gnt: got %b want 00", gnt); end
    tick();
    n_tests++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL drain_rvalid0: got %b want 10", rvalid); end
    n_tests++; if (rgb !== 12'h696) begin n_fail++; $display("FAIL drain_rgb0: got %h want 696", rgb); end
    tick();
    n_tests++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL drain_rvalid1: got %b want 01", rvalid); end
    n_tests++; if (rgb !== 12'h4B4) begin n_fail++; $display("FAIL drain_rgb1: got %h want 4B4", rgb); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy_hi: got %b want 1", busy); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy_lo: got %b want 0", busy); end
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL drain_idle_gnt: got %b want 00", gnt); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle_busy: got %b want 0", busy); end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    blank = 1'b0;
    tick();
    req = 2'b11; addr0 = 17'h00007; addr1 = 17'h00008;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_rvalid: got %b want 00", rvalid); end
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rstmid_rom_addr: got %h want 0", rom_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_tests++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rstmid_rgb: got %h want 000", rgb); end
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 00", gnt); end
    tick();
    rst_n = 1'b1; req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_post[%0d]: got %b want 00", k, rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_transparency();
    test_en_toggle();
    test_blank_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
